// File: rtl/mult_seq_pkg.sv
// Shared types and sizing for the sequential shift-add multiplier controller.
// Latency/backpressure: none (declarations only).
package mult_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Request/result handshake bundle between operand source, result consumer and controller.
// Latency/backpressure: wires only; req_ready and res_valid carry the flow control.
interface mult_seq_ctrl_if #(
  parameter int WIDTH = mult_seq_pkg::DEF_WIDTH
);

  logic               req_valid;
  logic               req_ready;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               res_valid;
  logic               res_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output req_valid, op_a, op_b, res_ready,
    input  req_ready, res_valid, product, busy
  );

  modport slave (
    input  req_valid, op_a, op_b, res_ready,
    output req_ready, res_valid, product, busy
  );

endinterface

// File: rtl/shift_add_core.sv
// Shift-add datapath: A/B/C registers, one unsigned add-and-shift step per step pulse.
// Latency: one cycle per operation; clr beats load beats step, no backpressure.
module shift_add_core
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] load_a,
  input  logic [WIDTH-1:0] load_b,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b
);

  logic [WIDTH-1:0] c;
  logic [WIDTH:0]   sum;

  // Carry-out becomes the new MSB of A; the bit shifted out of A enters B.
  assign sum = {1'b0, a} + (b[0] ? {1'b0, c} : '0);

  always_ff @(posedge clk) begin
    if (clr) begin
      a <= '0;
      b <= '0;
      c <= '0;
    end else if (load) begin
      a <= '0;
      b <= load_b;
      c <= load_a;
    end else if (step) begin
      a <= sum[WIDTH:1];
      b <= {sum[0], b[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the shift-add multiplier: accept, load, WIDTH steps, hold product until taken.
// Latency WIDTH+2 from accept; result held under res_ready backpressure. MULT_SEQ_ZERO_BYPASS_EN skips to DONE on zero operands.
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  mult_seq_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE  = S_IDLE;
  localparam logic [1:0] LOAD  = S_LOAD;
  localparam logic [1:0] RUN   = S_RUN;
  localparam logic [1:0] DONE  = S_DONE;
  localparam int         CNT_W = cnt_width(WIDTH);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic             accept;
  logic             last_step;
  logic             zero_op;
  logic             core_clr;

  assign accept    = (state == IDLE) && bus.req_valid;
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

`ifdef MULT_SEQ_ZERO_BYPASS_EN
  assign zero_op = (bus.op_a == '0) || (bus.op_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_a_q <= bus.op_a;
            op_b_q <= bus.op_b;
            state  <= zero_op ? DONE : LOAD;
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          if (last_step) state <= DONE;
          else           cnt   <= cnt + CNT_W'(1);
        end
        DONE: begin
          if (bus.res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A zero-operand bypass clears the datapath so {A,B} already reads 0 in DONE.
  assign core_clr = reset || (accept && zero_op);

  shift_add_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .clr    (core_clr),
    .load   (state == LOAD),
    .step   (state == RUN),
    .load_a (op_a_q),
    .load_b (op_b_q),
    .a      (core_a),
    .b      (core_b)
  );

  // {A,B} is the product register: it only moves in LOAD/RUN, so it is stable in DONE.
  assign bus.product   = {core_a, core_b};
  assign bus.req_ready = (state == IDLE);
  assign bus.res_valid = (state == DONE);
  assign bus.busy      = (state == LOAD) || (state == RUN);

endmodule
